dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and limits for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_W      = 32;
    localparam int BE_W        = WORD_W / 8;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [BE_W-1:0]          be_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder that stalls the pipeline LATENCY cycles per access.
// Optional byte-masked writes through be_i when DMEM_BYTE_MASK_EN is defined.
//
//   state   | meaning
//   IDLE    | no access in flight; req_i accepted (and stalls) here
//   WAIT    | counting down remaining stall cycles
//   DONE    | one-cycle completion, stall released, req_i ignored
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
`ifdef DMEM_BYTE_MASK_EN
    input  logic [BE_W-1:0]   be_i,
`endif
    output logic              stall_o,
    output logic              done_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              we_q;
    logic              mis_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              zero_q;

    logic              in_idle;
    logic              accept;
    logic              enter_done;
    logic              acc_we;
    logic              acc_mis;
    logic [IDX_W-1:0]  acc_idx;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              arr_en;
    logic [WORD_W-1:0] arr_rdata;
    logic              unused_addr;

    assign unused_addr = ^addr_i[WORD_W-1:IDX_W+2];

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = in_idle && req_i && !rst_i;

    // With LATENCY=1 the storage is touched on the accept edge itself,
    // before the request latches are loaded, so take the live inputs in IDLE.
    assign acc_we    = in_idle ? we_i                     : we_q;
    assign acc_mis   = in_idle ? is_misaligned(addr_i[1:0]) : mis_q;
    assign acc_idx   = in_idle ? addr_i[IDX_W+1:2]        : idx_q;
    assign acc_wdata = in_idle ? wdata_i                  : wdata_q;

`ifdef DMEM_BYTE_MASK_EN
    logic [BE_W-1:0] be_q;
    assign acc_be = in_idle ? be_i : be_q;
`else
    assign acc_be = {BE_W{1'b1}};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i && !rst_i) begin
                    stall_o = 1'b1;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign enter_done = (state_d == ST_DONE) && !rst_i;
    assign arr_en     = enter_done && !acc_mis;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef DMEM_BYTE_MASK_EN
            be_q    <= '0;
`endif
        end else if (accept) begin
            we_q    <= we_i;
            mis_q   <= is_misaligned(addr_i[1:0]);
            idx_q   <= addr_i[IDX_W+1:2];
            wdata_q <= wdata_i;
`ifdef DMEM_BYTE_MASK_EN
            be_q    <= be_i;
`endif
        end
    end

    // The array read register is not reset, so zero_q masks rdata_o until a
    // clean read lands, and forces zero after a misaligned completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zero_q <= 1'b1;
        end else if (enter_done) begin
            if (acc_mis) begin
                zero_q <= 1'b1;
            end else if (!acc_we) begin
                zero_q <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (arr_en),
        .we_i    (acc_we),
        .be_i    (acc_be),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    assign rdata_o = zero_q ? '0 : arr_rdata;
    assign err_o   = (state_q == ST_DONE) && mis_q;

endmodule
